// File: rtl/riscv_fetch_pkg.sv
// Shared constants and the prefetch queue entry type for the RV32I fetch stage.
package riscv_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with flush; the head is read straight from
// storage so there is no combinational path from push to the output.
module sync_fifo #(
  parameter int               WIDTH       = 64,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              AW          = $clog2(DEPTH),
  localparam int              CW          = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Flush has priority over any push or pop issued in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VALUE;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch: PC generation, credit-limited memory requests,
// prefetch queue toward the datapath, and redirect with stale-response drop.
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam fetch_entry_t RESET_ENTRY = '{pc: RESET_PC, inst: INST_NOP};

  // Handshakes: a transfer happens in any cycle where valid && ready at the
  // rising edge; valid never depends on ready, and once raised the offered
  // request/instruction stays put until accepted (redirect/reset excepted).

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   q_count;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            resp_keep;
  logic            q_empty;
  logic            q_pop;
  fetch_entry_t    q_in;
  fetch_entry_t    q_head;

  // Queued plus in-flight words never exceed DEPTH, so a response always has room.
  assign credit_used    = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_keep = imem_resp_valid && (drop == '0) && !redirect_valid;
  assign q_in      = '{pc: resp_pc, inst: imem_resp_data};

  assign inst_valid = !rst && !q_empty;
  assign inst       = rst ? INST_NOP : q_head.inst;
  assign inst_pc    = rst ? RESET_PC : q_head.pc;
  assign q_pop      = inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        // Every word still in flight belongs to the old path.
        fetch_pc <= align_pc(redirect_pc);
        resp_pc  <= align_pc(redirect_pc);
        drop     <= outstanding - CW'(imem_resp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (resp_keep) resp_pc <= resp_pc + PC_STEP;
        else if (imem_resp_valid) drop <= drop - 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH      ($bits(fetch_entry_t)),
    .DEPTH      (DEPTH),
    .RESET_VALUE(RESET_ENTRY)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (resp_keep),
    .push_data(q_in),
    .pop      (q_pop),
    .head     (q_head),
    .empty    (q_empty),
    .count    (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written
// redirect and mid-operation reset sequences, with an in-order memory model.
module tb_fetch_unit;
  import riscv_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5EED_0003;
  endfunction

  // ---------------- memory model: fixed latency, in order ----------------
  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend_q[$];

  always begin
    @(posedge clk);
    #2;
    cyc++;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (rst) begin
      pend_q.delete();
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    @(negedge clk);
    if (!rst && imem_req_valid && imem_req_ready) begin
      pend_t p;
      p.addr = imem_req_addr;
      p.due  = cyc + lat;
      pend_q.push_back(p);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every consumed instruction must match the next expected PC.
  task automatic mon();
    logic [31:0] e;
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%h expected=none", inst_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", inst_pc, e);
        chk("sb_inst", inst, mem_word(e));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    chk("leftover_expected", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, INST_NOP);
    chk("rst_inst_pc", inst_pc, RST_PC);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(negedge clk); #1;
    mon();
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rb;
    int          lt;
    logic        rd;
    logic [31:0] rpc;
    logic        ir;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic rb, input int lt, input logic rd, input logic [31:0] rpc,
                     input logic ir, input logic rv, input logic [31:0] addr,
                     input logic iv, input logic [31:0] pc);
    vec_t v;
    v.rb = rb; v.lt = lt; v.rd = rd; v.rpc = rpc; v.ir = ir;
    v.rv = rv; v.addr = addr; v.iv = iv; v.pc = pc;
    vecs.push_back(v);
  endtask

  initial begin
    // Streaming, k = 1, wraps through 0.
    add(1, 1, 0, 0, 1, 1, 32'hFFFF_FFF8, 0, 0);
    add(0, 1, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    add(0, 1, 0, 0, 1, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8);
    add(0, 1, 0, 0, 1, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
    add(0, 1, 0, 0, 1, 1, 32'h0000_0008, 1, 32'h0000_0000);
    add(0, 1, 0, 0, 1, 1, 32'h0000_000C, 1, 32'h0000_0004);
    // Backpressure: four requests, then stall with a stable head, then drain.
    add(1, 1, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 0);
    add(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    add(0, 1, 0, 0, 0, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8);
    add(0, 1, 0, 0, 0, 1, 32'h0000_0004, 1, 32'hFFFF_FFF8);
    add(0, 1, 0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFF8);
    add(0, 1, 0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFF8);
    add(0, 1, 0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFF8);
    add(0, 1, 0, 0, 1, 0, 32'h0,         1, 32'hFFFF_FFF8);
    add(0, 1, 0, 0, 1, 1, 32'h0000_0008, 1, 32'hFFFF_FFFC);
    add(0, 1, 0, 0, 1, 1, 32'h0000_000C, 1, 32'h0000_0000);
    add(0, 1, 0, 0, 1, 1, 32'h0000_0010, 1, 32'h0000_0004);
    add(0, 1, 0, 0, 1, 1, 32'h0000_0014, 1, 32'h0000_0008);
    add(0, 1, 0, 0, 1, 1, 32'h0000_0018, 1, 32'h0000_000C);
    // Redirect to 0x100 with 3 outstanding and one old response that cycle, k = 3.
    add(1, 3, 0, 0,          1, 1, 32'hFFFF_FFF8, 0, 0);
    add(0, 3, 0, 0,          1, 1, 32'hFFFF_FFFC, 0, 0);
    add(0, 3, 0, 0,          1, 1, 32'h0000_0000, 0, 0);
    add(0, 3, 1, 32'h100,    1, 0, 32'h0,         0, 0);
    add(0, 3, 0, 0,          1, 1, 32'h0000_0100, 0, 0);
    add(0, 3, 0, 0,          1, 1, 32'h0000_0104, 0, 0);
    add(0, 3, 0, 0,          1, 1, 32'h0000_0108, 0, 0);
    add(0, 3, 0, 0,          1, 1, 32'h0000_010C, 0, 0);
    add(0, 3, 0, 0,          1, 0, 32'h0,         1, 32'h0000_0100);
    add(0, 3, 0, 0,          1, 1, 32'h0000_0110, 1, 32'h0000_0104);
    add(0, 3, 0, 0,          1, 1, 32'h0000_0114, 1, 32'h0000_0108);

    foreach (vecs[i]) begin
      if (vecs[i].rb) do_reset();
      lat            = vecs[i].lt;
      inst_ready     = vecs[i].ir;
      redirect_valid = vecs[i].rd;
      redirect_pc    = vecs[i].rpc;
      if (vecs[i].ir && vecs[i].iv) exp_q.push_back(vecs[i].pc);
      @(negedge clk); #1;
      chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].rv));
      if (vecs[i].rv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].addr);
      chk($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].iv));
      if (vecs[i].iv) begin
        chk($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].pc);
        chk($sformatf("v%0d_inst", i), inst, mem_word(vecs[i].pc));
      end
      mon();
      @(posedge clk); #1;
      redirect_valid = 1'b0;
    end

    // Misaligned redirect to 0x203, then 0x400 the next cycle, k = 3.
    do_reset();
    lat        = 3;
    inst_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    @(negedge clk); #1;
    chk("redir1_req_valid", 32'(imem_req_valid), 32'd0);
    mon();
    @(posedge clk); #1;
    redirect_pc = 32'h0000_0400;
    @(negedge clk); #1;
    chk("redir2_req_valid", 32'(imem_req_valid), 32'd0);
    mon();
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk); #1;
    chk("redir2_first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("redir2_first_req_addr", imem_req_addr, 32'h0000_0400);
    exp_q.push_back(32'h0000_0400);
    exp_q.push_back(32'h0000_0404);
    exp_q.push_back(32'h0000_0408);
    @(posedge clk); #1;
    for (int n = 0; n < 30 && exp_q.size() > 0; n++) begin
      @(negedge clk); #1;
      if (imem_req_valid) chk("redir2_stream_addr", imem_req_addr & 32'hFFFF_FF00, 32'h0000_0400);
      mon();
      @(posedge clk); #1;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL redir2_timeout actual=%0d_left expected=0_left", exp_q.size());
      exp_q.delete();
    end

    // Fill the queue, reset for one cycle, expect fetch to restart at RESET_PC.
    do_reset();
    lat        = 1;
    inst_ready = 1'b0;
    repeat (7) step();
    @(negedge clk); #1;
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    chk("full_inst_valid", 32'(inst_valid), 32'd1);
    chk("full_inst_pc", inst_pc, RST_PC);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_inst", inst, INST_NOP);
    chk("midrst_inst_pc", inst_pc, RST_PC);
    @(posedge clk); #1;
    rst        = 1'b0;
    inst_ready = 1'b1;
    exp_q.push_back(RST_PC);
    exp_q.push_back(RST_PC + 32'd4);
    @(negedge clk); #1;
    chk("midrst_resume_req_valid", 32'(imem_req_valid), 32'd1);
    chk("midrst_resume_addr", imem_req_addr, RST_PC);
    chk("midrst_resume_inst_valid", 32'(inst_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("midrst_c2_inst_valid", 32'(inst_valid), 32'd0);
    @(posedge clk); #1;
    step();
    step();
    chk("final_leftover", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
